perf_counter_bank: RTL and testbench
====================================

# perf_counter_bank

Parametrised performance-counter bank, successor to the fixed four-counter unit (total cycles, jumps, taken branches, load-use stalls) that feeds the seven-segment display path. Provides NCH independent event counters of CW bits with selectable wrap or saturate mode, sticky overflow flags, global freeze, synchronous clear, an atomic snapshot into shadow registers, and a registered readout port. The readout port either follows a channel selector or auto-scans all channels for the display. It sits beside the pipeline, takes one-cycle event pulses from EX/REDIRECTION, and drives the data-to-show mux.

## Interface
- NCH, 4, number of counter channels (1..16)
- CW, 32, counter width in bits (8..64)
- SAT, 0, 0 = wrap at 2^CW, 1 = saturate at 2^CW-1
- SCAN_CYC, 50_000_000, cycles each channel is shown in scan mode (≥1)
- SW (localparam), max(1, clog2(NCH)), selector width

Ports:
- in_CLK  in  1  sole clock, all state on rising edge
- in_RST  in  1  synchronous reset, active-low
- EN  in  1  global count enable; 0 freezes all counters
- ev  in  NCH  event pulses; ev[i]=1 in a cycle counts one event on channel i
- clr  in  1  synchronous clear of counters and overflow flags
- snap  in  1  copy all counters into shadow registers
- scan  in  1  1 = auto-scan readout, 0 = readout follows sel
- sel  in  SW  readout channel when scan=0
- rd_data  out  CW  shadow value of channel cur_ch
- cur_ch  out  SW  channel currently in rd_data
- ovf  out  NCH  sticky overflow flags
- snap_done  out  1  one-cycle pulse, the cycle after a snapshot is taken

## Operation
- Reset (in_RST=0 at an edge): all counters, shadows, ovf, rd_data, cur_ch, scan state and snap_done go to 0.
- Per-channel priority each edge: reset > clr > count.
- Count: the counter increments when EN=1 and ev[i]=1. At most +1 per cycle.
- Wrap mode (SAT=0): when the counter is at 2^CW-1 and counts, it goes to 0 and ovf[i] is set.
- Saturate mode (SAT=1): when the counter is at 2^CW-1 and counts, it holds and ovf[i] is set.
- ovf[i] stays set until clr or reset.
- EN=0: counters and ovf hold. clr, snap and readout still operate.
- Snapshot: snap=1 loads every shadow[i] with the counter value before this edge's update, so all channels come from the same cycle. If clr and snap occur together, the shadows capture the old values and the counters go to 0.
- Readout selection: rd_ch = scan ? scan_ch : sel. Each edge, rd_data <= shadow[rd_ch] and cur_ch <= rd_ch. If rd_ch ≥ NCH, rd_data <= 0.
- Scan FSM, two states:
  - IDLE (scan=0): timer=0, scan_ch=0.
  - SCAN (scan=1): timer increments. When timer == SCAN_CYC-1, timer goes to 0 and scan_ch advances, wrapping from NCH-1 to 0.
  - scan falling returns the FSM to IDLE immediately.
  - Every entry into SCAN shows channel 0 for a full SCAN_CYC cycles.

## Timing
- ev → counter: visible in the counter 1 cycle later; visible in rd_data only after a snap.
- snap → shadow updated at that edge; snap_done high the following cycle; rd_data reflects the new shadow one further cycle later (snap at edge k, shadow at k, rd_data at k+1).
- sel change → rd_data/cur_ch updated at the next edge (latency 1).
- Scan dwell is exactly SCAN_CYC cycles per channel, including channel 0 on entry.
- Asserting reset mid-scan or mid-count clears everything at that edge; no partial state survives.

## Structure
- Package perf_pkg holds:
  - constants CNT_WRAP=0 and CNT_SAT=1
  - a clog2-based SW helper function
  - parameter range checks (elaboration-time assertions)
- Sub-module perf_counter_cell holds one channel: counter, ovf flag, shadow register, and wrap/sat logic parameterised by CW/SAT.
  - Instantiated NCH times in a generate loop.
  - The top level holds the scan FSM, the readout mux and snap_done.

## Test plan
- Reset, then ev=4'b1111 with EN=1 for 10 cycles, snap, sel=2 → rd_data=10, cur_ch=2, ovf=0, snap_done pulses one cycle after snap.
- CW=8, SAT=0, 257 events on ch1 → counter=1, ovf[1]=1. Repeat with SAT=1 → counter=255, ovf[1]=1. Then clr → counter=0, ovf=0.
- EN=0 with ev=4'b1111 for 20 cycles → counters unchanged. snap and readout still work. clr+snap in the same cycle → shadow holds old values, counters 0.
- snap asserted in the same cycle as an event on ch0 with counter=5 → shadow[0]=5, counter=6.
- scan=1, SCAN_CYC=3, NCH=4 → cur_ch sequence 0,0,0,1,1,1,2,2,2,3,3,3,0. Dropping scan mid-dwell → cur_ch follows sel next cycle. Re-raising scan → restarts at 0.
- NCH=3, sel=3 → rd_data=0. in_RST low mid-scan → all outputs 0 at the next edge.

Source files
------------

// File: rtl/perf_pkg.sv
// Shared constants, types and elaboration helpers for the performance-counter bank.
package perf_pkg;

    localparam int CNT_WRAP = 0;
    localparam int CNT_SAT  = 1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } scan_state_t;

    // Selector width; a single-channel bank still needs a one-bit selector port.
    function automatic int sel_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic bit cfg_ok(input int nch, input int cw, input int sat, input int scyc);
        return (nch >= 1) && (nch <= 16) && (cw >= 8) && (cw <= 64) &&
               ((sat == CNT_WRAP) || (sat == CNT_SAT)) && (scyc >= 1);
    endfunction

endpackage

// File: rtl/perf_counter_cell.sv
// One counter channel: event counter, sticky overflow flag and snapshot shadow.
module perf_counter_cell
    import perf_pkg::*;
#(
    parameter int CW  = 32,
    parameter int SAT = CNT_WRAP
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic          ev,
    input  logic          clr,
    input  logic          snap,
    output logic [CW-1:0] shadow,
    output logic          ovf
);

    logic [CW-1:0] count;
    logic          at_max;

    assign at_max = &count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count  <= '0;
            shadow <= '0;
            ovf    <= 1'b0;
        end else begin
            // Shadow takes the pre-update value so clr+snap still captures old data.
            if (snap)
                shadow <= count;
            if (clr) begin
                count <= '0;
                ovf   <= 1'b0;
            end else if (en && ev) begin
                if (at_max)
                    ovf <= 1'b1;
                if (!(at_max && SAT == CNT_SAT))
                    count <= count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/perf_counter_bank.sv
// NCH-channel performance counter bank with snapshot shadows and a scanning readout port.
module perf_counter_bank
    import perf_pkg::*;
#(
    parameter int NCH      = 4,
    parameter int CW       = 32,
    parameter int SAT      = CNT_WRAP,
    parameter int SCAN_CYC = 50_000_000,
    localparam int SW      = sel_width(NCH)
) (
    input  logic           in_CLK,
    input  logic           in_RST,
    input  logic           EN,
    input  logic [NCH-1:0] ev,
    input  logic           clr,
    input  logic           snap,
    input  logic           scan,
    input  logic [SW-1:0]  sel,
    output logic [CW-1:0]  rd_data,
    output logic [SW-1:0]  cur_ch,
    output logic [NCH-1:0] ovf,
    output logic           snap_done
);

    localparam int TW = (SCAN_CYC > 1) ? $clog2(SCAN_CYC) : 1;

    if (!cfg_ok(NCH, CW, SAT, SCAN_CYC)) begin : g_bad_cfg
        $error("perf_counter_bank: parameter out of range");
    end

    // Padded to the full selector range so out-of-range selects read zero.
    logic [CW-1:0] shadow [2**SW];

    for (genvar i = 0; i < 2**SW; i++) begin : g_ch
        if (i < NCH) begin : g_cell
            perf_counter_cell #(.CW(CW), .SAT(SAT)) u_cell (
                .clk    (in_CLK),
                .rst_n  (in_RST),
                .en     (EN),
                .ev     (ev[i]),
                .clr    (clr),
                .snap   (snap),
                .shadow (shadow[i]),
                .ovf    (ovf[i])
            );
        end else begin : g_pad
            assign shadow[i] = '0;
        end
    end

    scan_state_t   state;
    logic [TW-1:0] timer;
    logic [SW-1:0] scan_ch;
    logic [SW-1:0] rd_ch;

    always_ff @(posedge in_CLK) begin
        if (!in_RST) begin
            state   <= ST_IDLE;
            timer   <= '0;
            scan_ch <= '0;
        end else begin
            case (state)
                ST_IDLE: if (scan)  state <= ST_SCAN;
                ST_SCAN: if (!scan) state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
            // Timer runs from the first scan cycle so channel 0 gets a full dwell on entry.
            if (!scan) begin
                timer   <= '0;
                scan_ch <= '0;
            end else if (timer == TW'(SCAN_CYC - 1)) begin
                timer   <= '0;
                scan_ch <= (scan_ch == SW'(NCH - 1)) ? '0 : scan_ch + 1'b1;
            end else begin
                timer <= timer + 1'b1;
            end
        end
    end

    assign rd_ch = scan ? scan_ch : sel;

    always_ff @(posedge in_CLK) begin
        if (!in_RST) begin
            rd_data   <= '0;
            cur_ch    <= '0;
            snap_done <= 1'b0;
        end else begin
            rd_data   <= shadow[rd_ch];
            cur_ch    <= rd_ch;
            snap_done <= snap;
        end
    end

endmodule

// File: tb/tb_perf_counter_bank.sv
// Directed bench: three bank configurations share one stimulus stream.
module tb_perf_counter_bank;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0;
    logic [3:0] ev = '0;
    logic       clr = 1'b0;
    logic       snap = 1'b0;
    logic       scan = 1'b0;
    logic [1:0] sel = '0;

    logic [7:0] rd_a, rd_b, rd_c;
    logic [1:0] cur_a, cur_b, cur_c;
    logic [3:0] ovf_a, ovf_b;
    logic [2:0] ovf_c;
    logic       sd_a, sd_b, sd_c;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    perf_counter_bank #(.NCH(4), .CW(8), .SAT(0), .SCAN_CYC(3)) u_a (
        .in_CLK(clk), .in_RST(rst), .EN(en), .ev(ev), .clr(clr), .snap(snap),
        .scan(scan), .sel(sel), .rd_data(rd_a), .cur_ch(cur_a), .ovf(ovf_a), .snap_done(sd_a));

    perf_counter_bank #(.NCH(4), .CW(8), .SAT(1), .SCAN_CYC(3)) u_b (
        .in_CLK(clk), .in_RST(rst), .EN(en), .ev(ev), .clr(clr), .snap(snap),
        .scan(scan), .sel(sel), .rd_data(rd_b), .cur_ch(cur_b), .ovf(ovf_b), .snap_done(sd_b));

    perf_counter_bank #(.NCH(3), .CW(8), .SAT(0), .SCAN_CYC(2)) u_c (
        .in_CLK(clk), .in_RST(rst), .EN(en), .ev(ev[2:0]), .clr(clr), .snap(snap),
        .scan(scan), .sel(sel), .rd_data(rd_c), .cur_ch(cur_c), .ovf(ovf_c), .snap_done(sd_c));

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    int seq_a [13] = '{0, 0, 0, 1, 1, 1, 2, 2, 2, 3, 3, 3, 0};
    int seq_c [13] = '{0, 0, 1, 1, 2, 2, 0, 0, 1, 1, 2, 2, 0};
    int re_a [4] = '{0, 0, 0, 1};
    int re_c [4] = '{0, 0, 1, 1};

    initial begin
        // reset
        step(2);
        chk("rst_rd", rd_a, 0);
        chk("rst_cur", cur_a, 0);
        chk("rst_ovf", ovf_a, 0);
        chk("rst_sd", sd_a, 0);
        rst = 1'b1;

        // 10 events on all channels, snapshot, read ch2
        en = 1'b1; ev = 4'b1111;
        step(10);
        ev = '0; snap = 1'b1; sel = 2'd2;
        step(1);
        snap = 1'b0;
        chk("sd_pulse", sd_a, 1);
        step(1);
        chk("sd_drop", sd_a, 0);
        chk("rd10_a", rd_a, 10);
        chk("rd10_c", rd_c, 10);
        chk("cur2", cur_a, 2);
        chk("ovf0", ovf_a, 0);

        // 257 events on ch1: wrap vs saturate
        clr = 1'b1;
        step(1);
        clr = 1'b0; ev = 4'b0010;
        step(255);
        chk("ovf_at_max", ovf_a, 0);
        step(2);
        ev = '0;
        chk("ovf_wrap", ovf_a, 4'b0010);
        chk("ovf_sat", ovf_b, 4'b0010);
        chk("ovf_c", ovf_c, 3'b010);
        snap = 1'b1; sel = 2'd1;
        step(1);
        snap = 1'b0;
        step(1);
        chk("wrap_cnt", rd_a, 1);
        chk("sat_cnt", rd_b, 255);
        chk("wrap_cnt_c", rd_c, 1);

        // clear
        clr = 1'b1;
        step(1);
        clr = 1'b0;
        chk("clr_ovf_a", ovf_a, 0);
        chk("clr_ovf_b", ovf_b, 0);
        snap = 1'b1;
        step(1);
        snap = 1'b0;
        step(1);
        chk("clr_cnt_b", rd_b, 0);

        // freeze with EN=0
        ev = 4'b1111;
        step(5);
        en = 1'b0;
        step(20);
        ev = '0;
        snap = 1'b1; sel = 2'd3;
        step(1);
        snap = 1'b0;
        step(1);
        chk("frz_rd", rd_a, 5);
        chk("frz_cur", cur_a, 3);
        chk("sel_oob_rd", rd_c, 0);
        chk("sel_oob_cur", cur_c, 3);

        // clr together with snap
        en = 1'b1; ev = 4'b1111;
        step(2);
        ev = '0; clr = 1'b1; snap = 1'b1;
        step(1);
        clr = 1'b0; snap = 1'b0;
        step(1);
        chk("clrsnap_shadow", rd_a, 7);
        snap = 1'b1;
        step(1);
        snap = 1'b0;
        step(1);
        chk("clrsnap_cnt", rd_a, 0);

        // snap coincident with an event
        ev = 4'b0001;
        step(5);
        snap = 1'b1;
        step(1);
        snap = 1'b0; ev = '0; sel = 2'd0;
        step(1);
        chk("snapev_shadow", rd_a, 5);
        chk("snapev_cur", cur_a, 0);
        snap = 1'b1;
        step(1);
        snap = 1'b0;
        step(1);
        chk("snapev_cnt", rd_a, 6);

        // scan dwell sequence
        scan = 1'b1;
        for (int i = 0; i < 13; i++) begin
            step(1);
            chk($sformatf("scan_a%0d", i), cur_a, seq_a[i]);
            chk($sformatf("scan_c%0d", i), cur_c, seq_c[i]);
        end
        step(1);
        scan = 1'b0; sel = 2'd2;
        step(1);
        chk("drop_cur", cur_a, 2);
        chk("drop_rd", rd_a, 0);
        scan = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step(1);
            chk($sformatf("rescan_a%0d", i), cur_a, re_a[i]);
            chk($sformatf("rescan_c%0d", i), cur_c, re_c[i]);
        end

        // reset mid-scan
        scan = 1'b0; sel = 2'd0;
        step(1);
        chk("pre_rst_rd", rd_a, 6);
        ev = 4'b1111; scan = 1'b1; snap = 1'b1; rst = 1'b0;
        step(1);
        chk("mid_rst_rd", rd_a, 0);
        chk("mid_rst_cur", cur_a, 0);
        chk("mid_rst_ovf", ovf_a, 0);
        chk("mid_rst_sd", sd_a, 0);
        ev = '0; snap = 1'b0; rst = 1'b1;
        step(1);
        chk("post_rst_cur", cur_a, 0);
        snap = 1'b1;
        step(1);
        snap = 1'b0;
        step(1);
        chk("post_rst_rd", rd_a, 0);
        chk("post_rst_cur2", cur_a, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
